mdu_seq: RTL

- Parametrised multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the E stage beside the ALU and drives the XALUOut path.
- Accepts one operation at a time via a start pulse and exposes a busy flag to the hazard/pause unit.
- Generalises the single-cycle ALU datapath:
  - configurable data width;
  - independent, configurable multiply and divide latencies;
  - signed/unsigned modes;
  - abort on pipeline flush.

---
 rtl/mdu_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers; one op at a time, busy for MUL_CYCLES or DIV_CYCLES.
// Result computed from latched operands and committed on the final busy edge; abort discards it.
module mdu_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic               is_signed, a_neg, b_neg, accept;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_mag, rem_mag, div_q, div_r;

  // op_q[0] clear selects the signed flavour for both MULT and DIV
  always_comb begin
    is_signed = ~op_q[0];
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    a_ext     = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext     = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod      = a_ext * b_ext;
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    quo_mag   = a_mag / b_mag;
    rem_mag   = a_mag % b_mag;
    div_q     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    div_r     = a_neg ? -rem_mag : rem_mag;
    if (b_q == '0) begin
      div_q = '1;
      div_r = a_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    accept  = start & ~abort & (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              state_d = S_RUN;
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b;
              cnt_d   = op[1] ? DIV_LOAD : MUL_LOAD;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (op_q[1]) begin
            hi_d = div_r;
            lo_d = div_q;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
